// File: rtl/bsg_manycore_torus_link_vc_buffer.sv
// ---------------------------------------------------------------------------
// bsg_manycore_torus_link_vc_buffer
//
// Per-direction torus link stage placed between neighbouring routers.
// Incoming flits are credit-guaranteed (no ready). Each flit is stored in the
// FIFO of its upstream VC. A round-robin arbiter moves at most one flit per
// cycle into a registered output stage. A VC may send only while the
// downstream credit counter of its output VC is non-zero. On dateline links,
// VC0 traffic leaves on VC1. Each dequeue returns a one-cycle credit pulse
// upstream.
//
// Ports
//   clk_i         clock
//   reset_ni      async active-low reset; deassertion is synchronised internally
//   in_v_i        incoming flit valid
//   in_vc_i       VC of the incoming flit (selects the FIFO)
//   in_data_i     incoming flit payload
//   in_credit_o   per-VC credit pulse to upstream (one-hot or zero)
//   out_v_o       outgoing flit valid (registered)
//   out_vc_o      outgoing VC after dateline remap (registered)
//   out_data_o    outgoing flit payload (registered, holds when idle)
//   out_credit_i  per-VC credit pulse from downstream
//   stall_cnt_o   per-VC stall counters, 32 bits each
//
// Optional feature macro: BSG_MANYCORE_TORUS_LINK_STATS_EN
//   Defined     - stall_cnt_o[q*32+:32] counts the cycles in which FIFO[q]
//                 holds a flit but its output VC has no credit. The counter
//                 saturates at all-ones.
//   Not defined - no counters are built and stall_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module bsg_manycore_torus_link_vc_buffer #(
    parameter int  width_p        = 64,
    parameter int  num_vc_p       = 2,
    parameter int  els_p          = 4,
    parameter int  down_credits_p = 4,
    parameter int  dateline_p     = 0,
    localparam int vc_w_lp        = (num_vc_p > 1) ? $clog2(num_vc_p) : 1,
    localparam int cnt_w_lp       = (down_credits_p > 0) ? $clog2(down_credits_p + 1) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     in_v_i,
    input  logic [vc_w_lp-1:0]       in_vc_i,
    input  logic [width_p-1:0]       in_data_i,
    output logic [num_vc_p-1:0]      in_credit_o,
    output logic                     out_v_o,
    output logic [vc_w_lp-1:0]       out_vc_o,
    output logic [width_p-1:0]       out_data_o,
    input  logic [num_vc_p-1:0]      out_credit_i,
    output logic [num_vc_p*32-1:0]   stall_cnt_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int occ_w_lp = $clog2(els_p + 1);

    // Output VC for queue q: VC0 crosses to VC1 on a dateline link.
    function automatic logic [vc_w_lp-1:0] ovc(input logic [vc_w_lp-1:0] q);
        if (dateline_p != 0 && q == '0) return vc_w_lp'(1);
        return q;
    endfunction

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, release waits two edges.
    // -----------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // NOTE: clocked state is always written with non-blocking assignments so
    // every register in a block sees the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [width_p-1:0]  mem_q    [num_vc_p][els_p];
    logic [ptr_w_lp-1:0] wr_ptr_q [num_vc_p];
    logic [ptr_w_lp-1:0] rd_ptr_q [num_vc_p];
    logic [occ_w_lp-1:0] occ_q    [num_vc_p];
    logic [cnt_w_lp-1:0] cnt_q    [num_vc_p];
    logic [vc_w_lp-1:0]  ptr_q;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic                enq;
    logic [num_vc_p-1:0] enq_vec;
    logic [num_vc_p-1:0] deq_vec;
    logic [num_vc_p-1:0] eligible;
    logic [num_vc_p-1:0] send;
    logic [num_vc_p-1:0] credit_next;
    logic                grant;
    logic [vc_w_lp-1:0]  win;
    logic [vc_w_lp-1:0]  ptr_next;

    // A flit aimed at a full FIFO is dropped. A same-cycle dequeue does not
    // make room, because upstream never holds a credit for that slot.
    assign enq = in_v_i && (occ_q[in_vc_i] != occ_w_lp'(els_p));

    // A flit must already be resident to be eligible. There is no bypass.
    // NOTE: each combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        eligible = '0;
        for (int q = 0; q < num_vc_p; q++) begin
            eligible[q] = (occ_q[q] != '0) && (cnt_q[ovc(vc_w_lp'(q))] != '0);
        end
    end

    // Round-robin search starting at ptr_q. The first eligible VC wins.
    always_comb begin
        int idx;
        idx   = 0;
        grant = 1'b0;
        win   = '0;
        for (int i = 0; i < num_vc_p; i++) begin
            idx = (int'(ptr_q) + i) % num_vc_p;
            if (!grant && eligible[idx]) begin
                grant = 1'b1;
                win   = vc_w_lp'(idx);
            end
        end
    end

    assign ptr_next = vc_w_lp'((int'(win) + 1) % num_vc_p);

    always_comb begin
        enq_vec     = '0;
        deq_vec     = '0;
        send        = '0;
        credit_next = '0;
        if (enq)   enq_vec[in_vc_i] = 1'b1;
        if (grant) begin
            deq_vec[win]     = 1'b1;
            credit_next[win] = 1'b1;
            send[ovc(win)]   = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage and pointers
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset. Occupancy and pointers are reset,
    // and they gate every read, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[in_vc_i][wr_ptr_q[in_vc_i]] <= in_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < num_vc_p; q++) begin
                wr_ptr_q[q] <= '0;
                rd_ptr_q[q] <= '0;
                occ_q[q]    <= '0;
            end
        end else begin
            for (int q = 0; q < num_vc_p; q++) begin
                if (enq_vec[q]) wr_ptr_q[q] <= ptr_inc(wr_ptr_q[q]);
                if (deq_vec[q]) rd_ptr_q[q] <= ptr_inc(rd_ptr_q[q]);
                if (enq_vec[q] && !deq_vec[q])      occ_q[q] <= occ_q[q] + occ_w_lp'(1);
                else if (!enq_vec[q] && deq_vec[q]) occ_q[q] <= occ_q[q] - occ_w_lp'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output stage, upstream credits, RR pointer, downstream credit counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            out_v_o     <= 1'b0;
            out_vc_o    <= '0;
            out_data_o  <= '0;
            in_credit_o <= '0;
            ptr_q       <= '0;
            for (int v = 0; v < num_vc_p; v++) cnt_q[v] <= cnt_w_lp'(down_credits_p);
        end else begin
            out_v_o     <= grant;
            in_credit_o <= credit_next;
            if (grant) begin
                out_vc_o   <= ovc(win);
                out_data_o <= mem_q[win][rd_ptr_q[win]];
                ptr_q      <= ptr_next;
            end
            // A send and a credit return in the same cycle cancel out.
            for (int v = 0; v < num_vc_p; v++) begin
                if (send[v] && !out_credit_i[v])      cnt_q[v] <= cnt_q[v] - cnt_w_lp'(1);
                else if (!send[v] && out_credit_i[v]) cnt_q[v] <= cnt_q[v] + cnt_w_lp'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Optional stall statistics
    // -----------------------------------------------------------------------
`ifdef BSG_MANYCORE_TORUS_LINK_STATS_EN
    logic [31:0]         stall_q [num_vc_p];
    logic [num_vc_p-1:0] stalled;

    always_comb begin
        stalled = '0;
        for (int q = 0; q < num_vc_p; q++) begin
            stalled[q] = (occ_q[q] != '0) && (cnt_q[ovc(vc_w_lp'(q))] == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < num_vc_p; q++) stall_q[q] <= '0;
        end else begin
            for (int q = 0; q < num_vc_p; q++) begin
                if (stalled[q] && stall_q[q] != 32'hFFFF_FFFF) stall_q[q] <= stall_q[q] + 32'd1;
            end
        end
    end

    always_comb begin
        stall_cnt_o = '0;
        for (int q = 0; q < num_vc_p; q++) stall_cnt_o[q*32 +: 32] = stall_q[q];
    end
`else
    assign stall_cnt_o = '0;
`endif

    // -----------------------------------------------------------------------
    // Protocol checks
    // -----------------------------------------------------------------------
    a_enq_full: assert property (@(posedge clk_i) disable iff (!rst_n)
        !(in_v_i && !enq));

    for (genvar v = 0; v < num_vc_p; v++) begin : g_cnt_chk
        a_cnt_over: assert property (@(posedge clk_i) disable iff (!rst_n)
            !(out_credit_i[v] && !send[v] && cnt_q[v] == cnt_w_lp'(down_credits_p)));
        a_cnt_under: assert property (@(posedge clk_i) disable iff (!rst_n)
            !(send[v] && cnt_q[v] == '0));
    end

endmodule
